// File: rtl/dds_poly_seq.sv
// Horner sequencer for piecewise-quadratic DDS: fetches A0/A1/A2 for a phase segment and
// evaluates ((A2*x)>>>F + A1)*x>>>F + A0 on one time-shared signed multiplier.
module dds_poly_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned PHASE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHASE_WIDTH-1:0] in_phase,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_a0,
    input  logic [DATA_WIDTH-1:0]  rom_a1,
    input  logic [DATA_WIDTH-1:0]  rom_a2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy
);

    localparam int unsigned F  = PHASE_WIDTH - ADDR_WIDTH;
    localparam int unsigned PW = DATA_WIDTH + F + 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StMul1, StAdd1, StMul2, StAdd2, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  seg_q;
    logic [F-1:0]           x_q;
    logic signed [PW-1:0]   prod_q;
    logic [DATA_WIDTH-1:0]  t_q;
    logic [DATA_WIDTH-1:0]  out_data_q;

    logic                   hs;
    logic signed [DATA_WIDTH-1:0] mul_a;
    logic signed [F:0]      mul_b;
    logic signed [PW-1:0]   mul_res;
    logic signed [PW-1:0]   prod_sh;
    logic [DATA_WIDTH-1:0]  add_b;
    logic [DATA_WIDTH-1:0]  sum;
    logic                   unused_prod;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign hs        = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rom_en    = (state_q == StFetch);
    assign rom_addr  = seg_q;
    assign out_data  = out_data_q;

    // The single multiplier: A2*x in MUL1, t*x in MUL2; x is an unsigned fraction.
    assign mul_a   = (state_q == StMul1) ? rom_a2 : t_q;
    assign mul_b   = {1'b0, x_q};
    assign mul_res = PW'(mul_a) * PW'(mul_b);

    // Arithmetic shift floors toward -inf; sums wrap modulo 2^DATA_WIDTH.
    assign prod_sh     = prod_q >>> F;
    assign add_b       = (state_q == StAdd1) ? rom_a1 : rom_a0;
    assign sum         = prod_sh[DATA_WIDTH-1:0] + add_b;
    assign unused_prod = ^prod_sh[PW-1:DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hs) state_d = StFetch;
            StFetch: state_d = StMul1;
            StMul1:  state_d = StAdd1;
            StAdd1:  state_d = StMul2;
            StMul2:  state_d = StAdd2;
            StAdd2:  state_d = StDone;
            StDone: begin
                if (out_ready) state_d = in_valid ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seg_q      <= '0;
            x_q        <= '0;
            prod_q     <= '0;
            t_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                seg_q <= in_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
                x_q   <= in_phase[F-1:0];
            end
            if (state_q == StMul1 || state_q == StMul2) prod_q <= mul_res;
            if (state_q == StAdd1) t_q <= sum;
            if (state_q == StAdd2) out_data_q <= sum;
        end
    end

endmodule

// File: tb/tb_dds_poly_seq.sv
// Directed bench for dds_poly_seq: table of hand-computed Horner vectors plus reset,
// backpressure and streaming sequences, with a registered coefficient ROM model.
module tb_dds_poly_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_phase;
    logic        rom_en;
    logic [4:0]  rom_addr;
    logic [31:0] rom_a0, rom_a1, rom_a2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic [31:0] a0_mem [32];
    logic [31:0] a1_mem [32];
    logic [31:0] a2_mem [32];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    dds_poly_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_a0    (rom_a0),
        .rom_a1    (rom_a1),
        .rom_a2    (rom_a2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Registered ROMs, outputs held while rom_en is low
    always @(posedge clk) begin
        if (rom_en) begin
            rom_a0 <= a0_mem[rom_addr];
            rom_a1 <= a1_mem[rom_addr];
            rom_a2 <= a2_mem[rom_addr];
        end
    end

    typedef struct {
        string       name;
        logic [4:0]  seg;
        logic [10:0] x;
        logic [31:0] a2;
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic load(input logic [4:0] seg, input logic [31:0] a2, input logic [31:0] a1,
                        input logic [31:0] a0);
        a2_mem[seg] = a2;
        a1_mem[seg] = a1;
        a0_mem[seg] = a0;
    endtask

    // Called at #1 after handshake edge k (state FETCH); checks the ROM access and latency,
    // leaves the result presented (out_valid high) without consuming it.
    task automatic after_hs(input string name, input logic [4:0] seg, input logic [31:0] exp);
        int n;
        check({name, " fetch"}, 32'({rom_en, rom_addr}), 32'({1'b1, seg}));
        check({name, " busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({name, " rom_en pulse"}, 32'(rom_en), 32'd0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, 32'd5);
        check({name, " data"}, out_data, exp);
    endtask

    task automatic accept(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " valid drop"}, 32'({out_valid, busy}), 32'd0);
    endtask

    task automatic start(input logic [4:0] seg, input logic [10:0] x);
        @(negedge clk);
        in_valid = 1'b1;
        in_phase = {seg, x};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          idx, got, last;
        logic        hs;
        logic [31:0] sexp [4];

        vecs[0] = '{"basic",  5'd3,  11'h400, 32'h00001000, 32'h00000100, 32'h00000010, 32'h00000490};
        vecs[1] = '{"floor1", 5'd1,  11'h001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{"floor2", 5'd2,  11'h400, 32'hFFFFF000, 32'h00000000, 32'h00000000, 32'hFFFFFC00};
        vecs[3] = '{"wrap",   5'd12, 11'h7FF, 32'h00000000, 32'h00000800, 32'h7FFFFFFF, 32'h800007FE};
        vecs[4] = '{"x0s31",  5'd31, 11'h000, 32'h12345678, 32'h9ABCDEF0, 32'hD8C01630, 32'hD8C01630};
        vecs[5] = '{"seg0",   5'd0,  11'h100, 32'h00000000, 32'h00000400, 32'h00000001, 32'h00000081};

        for (int i = 0; i < 32; i++) load(5'(i), 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0; in_valid = 1'b0; in_phase = '0; out_ready = 1'b0;
        rom_a0 = '0; rom_a1 = '0; rom_a2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'({out_valid, rom_en, busy, in_ready}), 32'b0001);
        check("reset out_data", out_data, 32'h0);
        check("reset rom_addr", 32'(rom_addr), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].seg, vecs[i].a2, vecs[i].a1, vecs[i].a0);
            start(vecs[i].seg, vecs[i].x);
            after_hs(vecs[i].name, vecs[i].seg, vecs[i].exp);
            accept(vecs[i].name);
        end

        // Asynchronous reset in the middle of ADD1
        start(5'd3, 11'h400);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst outputs", 32'({out_valid, rom_en, busy, in_ready}), 32'b0001);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || busy) n++;
        end
        check("midrst no output", n, 32'd0);

        // Backpressure, then simultaneous output/input handshake
        load(5'd9, 32'h0, 32'h0, 32'h12345678);
        load(5'd10, 32'h0, 32'h0, 32'hCAFEF00D);
        start(5'd9, 11'h005);
        after_hs("bp first", 5'd9, 32'h12345678);
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== 32'h12345678 || in_ready) n++;
        end
        check("bp hold stable", n, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_phase  = {5'd10, 11'h000};
        #1;
        check("bp in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp both hs", 32'(out_valid), 32'd0);
        after_hs("bp second", 5'd10, 32'hCAFEF00D);
        accept("bp second");

        // Stream four phases with out_ready held high
        for (int i = 0; i < 4; i++) begin
            load(5'(4 + i), 32'h0, 32'h100, 32'((i + 1) * 32'h1000));
            sexp[i] = 32'((i + 1) * 32'h1000) + 32'h40;
        end
        idx = 0; got = 0; last = 0;
        @(negedge clk) out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            in_valid = (idx < 4);
            in_phase = (idx < 4) ? {5'(4 + idx), 11'h200} : 16'h0;
            #1 hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) idx++;
            #1;
            if (out_valid) begin
                check("stream data", out_data, sexp[got]);
                if (got > 0) check("stream spacing", cyc - last, 32'd6);
                last = cyc;
                got++;
            end
        end
        check("stream count", got, 32'd4);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
